vfp_config_bank: RTL and testbench
==================================

# vfp_config_bank

Run-time configuration register bank for the video frame processing (VFP) pipeline. It replaces compile-time image and revision constants with software-writable staging registers. Staged values are promoted to an active set only at a start-of-frame boundary, so downstream stream blocks never see a configuration change mid-frame. It sits between the processor-side configuration bus and the RGB stream stages, and also exposes a frame counter and a sticky error status.

## Interface
- DATA_WIDTH, 32, config bus data width
- ADDR_WIDTH, 8, config bus byte-address width
- REVISION, 32'h09072019, value returned by REVISION register
- IMG_WIDTH_MAX, 2751, upper clamp for IMG_WIDTH
- IMG_HEIGHT_MAX, 1944, upper clamp for IMG_HEIGHT
- NUM_USER, 4, number of general-purpose RW user registers (1..16)
- aclk  in  1  sole clock
- aresetn  in  1  asynchronous active-low reset
- wr_valid  in  1  write request, single-cycle accept
- wr_addr  in  ADDR_WIDTH  byte address; word index = wr_addr[ADDR_WIDTH-1:2]
- wr_data  in  DATA_WIDTH  write data
- wr_ready  out  1  constant 1 after reset; 0 during reset
- rd_valid  in  1  read request
- rd_addr  in  ADDR_WIDTH  byte address
- rd_dvalid  out  1  read data valid, one cycle after rd_valid
- rd_data  out  DATA_WIDTH  read data
- sof  in  1  start-of-frame pulse from the video timing stage
- cfg_enable  out  1  active enable
- cfg_mode  out  2  active mode
- cfg_img_width  out  12  active image width
- cfg_img_height  out  12  active image height
- cfg_user  out  NUM_USER*DATA_WIDTH  active user registers; reg 0 at LSBs
- cfg_pending  out  1  staged update awaiting sof

## Operation
- Register map (byte address):
  - 0x00 REVISION: RO.
  - 0x04 CONTROL: bit0 enable, bits[3:2] mode (staged); bit1 UPDATE is write-1, self-clearing, and reads 0.
  - 0x08 IMG_WIDTH: [11:0], staged.
  - 0x0C IMG_HEIGHT: [11:0], staged.
  - 0x10 STATUS: bit0 pending (RO); bit1 err (W1C).
  - 0x14 FRAME_CNT: RO, 32-bit.
  - 0x18 + 4*k: USER[k] for k < NUM_USER, staged.
- Staging writes to IMG_WIDTH and IMG_HEIGHT:
  - A value above MAX is clamped to MAX, and err is set.
  - A value of 0 is rejected (staging unchanged), and err is set.
- Unmapped address (write or read): write ignored, read returns 0, err set.
- Staging reads return staged values, not active values.
- Writing CONTROL with bit1=1 sets pending.
- On sof with pending=1: all staged fields are copied to the active outputs and pending clears.
- On sof with pending=0: active outputs hold.
- FRAME_CNT increments on every sof and wraps 0xFFFFFFFF -> 0.
- Simultaneous events:
  - UPDATE write and sof in the same cycle: pending sets, and the copy happens at the next sof.
  - Staging write and promoting sof in the same cycle: active takes the pre-write staged value; the new staged value remains for the next update.
  - err W1C and a new error in the same cycle: err stays 1.
  - Read and write to the same address in the same cycle: read returns the pre-write value.

## Timing
- Reset values (async assert, sync-released use), for both staging and active:
  - enable 0, mode 0.
  - IMG_WIDTH = IMG_WIDTH_MAX, IMG_HEIGHT = IMG_HEIGHT_MAX.
  - USER = 0.
  - pending 0, err 0, FRAME_CNT 0.
  - rd_dvalid 0, rd_data 0, wr_ready 0.
- Write accepted on a clock edge with wr_valid=1; staging is visible to a read issued the following cycle.
- Read latency 1 cycle: rd_dvalid registered, rd_data held until the next read.
- Back-to-back reads supported every cycle.
- Active outputs change exactly 1 cycle after the sof edge; cfg_pending falls in the same cycle.
- Reset asserted mid-frame or with pending=1 discards everything, with no partial promotion.

## Test plan
- Reset: read 0x00 -> 0x09072019. Read 0x08 -> 2751. cfg_img_width = 2751, cfg_enable = 0.
- Write IMG_WIDTH=1920 and CONTROL=0x3, then pulse sof -> cfg_img_width = 1920 and cfg_enable = 1 one cycle after sof; cfg_pending 1 -> 0.
- Write IMG_WIDTH=1280 without UPDATE, then pulse sof -> cfg_img_width stays 1920; reading 0x08 returns 1280.
- Write IMG_WIDTH=4000 -> reads 2751, STATUS=0x2. Write IMG_WIDTH=0 -> unchanged, err=1. Write 0x2 to 0x10 -> STATUS=0.
- UPDATE write in the same cycle as sof -> no change that cycle, pending=1; next sof promotes. 3 sof pulses -> FRAME_CNT increases by 3. Preload 0xFFFFFFFF and pulse sof -> 0.
- Write USER[3] = 0xA5A5A5A5, UPDATE, sof, then assert aresetn low mid-frame -> all active outputs and FRAME_CNT return to reset values immediately.

Source files
------------

// File: rtl/vfp_config_bank_if.sv
// Configuration bus between the processor side and vfp_config_bank.
// Writes are accepted in one cycle. Reads return data one cycle after the request.
//   master : drives the request fields wr_* and rd_valid/rd_addr
//   slave  : drives wr_ready, rd_dvalid and rd_data
interface vfp_config_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_dvalid;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    input  wr_ready, rd_dvalid, rd_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    output wr_ready, rd_dvalid, rd_data
  );
endinterface

// File: rtl/vfp_config_bank.sv
// Run-time configuration bank for the VFP stream pipeline.
// Software writes go into staging registers. The staged set is copied to the
// active cfg_* outputs only on a sof pulse, and only after an UPDATE request.
// This keeps the configuration stable for the whole of a frame.
// Ports:
//   aclk, aresetn  : clock, asynchronous active-low reset
//   bus            : config bus (slave modport); single-cycle writes, 1-cycle read latency
//   sof            : start-of-frame pulse
//   cfg_*          : active configuration; cfg_pending = an update is waiting for sof
module vfp_config_bank #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 8,
  parameter logic [31:0] REVISION       = 32'h09072019,
  parameter int          IMG_WIDTH_MAX  = 2751,
  parameter int          IMG_HEIGHT_MAX = 1944,
  parameter int          NUM_USER       = 4
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  vfp_config_bank_if.slave               bus,
  input  logic                           sof,
  output logic                           cfg_enable,
  output logic [1:0]                     cfg_mode,
  output logic [11:0]                    cfg_img_width,
  output logic [11:0]                    cfg_img_height,
  output logic [NUM_USER*DATA_WIDTH-1:0] cfg_user,
  output logic                           cfg_pending
);
  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [IW-1:0] IDX_REV  = IW'(0);
  localparam logic [IW-1:0] IDX_CTRL = IW'(1);
  localparam logic [IW-1:0] IDX_WID  = IW'(2);
  localparam logic [IW-1:0] IDX_HGT  = IW'(3);
  localparam logic [IW-1:0] IDX_STAT = IW'(4);
  localparam logic [IW-1:0] IDX_CNT  = IW'(5);
  localparam int            IDX_USER0 = 6;
  localparam logic [11:0]   W_MAX = 12'(IMG_WIDTH_MAX);
  localparam logic [11:0]   H_MAX = 12'(IMG_HEIGHT_MAX);

  // staging and active register sets
  logic                                stg_enable, act_enable;
  logic [1:0]                          stg_mode, act_mode;
  logic [11:0]                         stg_width, act_width;
  logic [11:0]                         stg_height, act_height;
  logic [NUM_USER-1:0][DATA_WIDTH-1:0] stg_user, act_user;
  logic                                pending, err;
  logic [31:0]                         frame_cnt;
  logic                                wr_ready_q, rd_dvalid_q;
  logic [DATA_WIDTH-1:0]               rd_data_q;

  logic [IW-1:0]       wr_idx, rd_idx;
  logic                wr_en, wr_hit, img_err, upd_wr, err_clr, err_set;
  logic [11:0]         wv;
  logic [NUM_USER-1:0] wr_user;
  logic                rd_user_hit, rd_hit;
  logic [DATA_WIDTH-1:0] rd_user_word, rd_word;
  logic                unused;

  assign wr_idx = bus.wr_addr[ADDR_WIDTH-1:2];
  assign rd_idx = bus.rd_addr[ADDR_WIDTH-1:2];
  assign wr_en  = bus.wr_valid & wr_ready_q;
  assign wv     = bus.wr_data[11:0];
  assign unused = ^{bus.wr_addr[1:0], bus.rd_addr[1:0]};

  always_comb begin
    wr_user      = '0;
    rd_user_hit  = 1'b0;
    rd_user_word = '0;
    for (int k = 0; k < NUM_USER; k++) begin
      wr_user[k] = (wr_idx == IW'(IDX_USER0 + k));
      if (rd_idx == IW'(IDX_USER0 + k)) begin
        rd_user_hit  = 1'b1;
        rd_user_word = stg_user[k];
      end
    end
  end

  // A zero size is rejected and an oversize value is clamped. Both raise err.
  assign wr_hit  = (wr_idx <= IDX_CNT) | (|wr_user);
  assign img_err = ((wr_idx == IDX_WID) && (wv > W_MAX || wv == 12'd0)) ||
                   ((wr_idx == IDX_HGT) && (wv > H_MAX || wv == 12'd0));
  assign upd_wr  = wr_en && (wr_idx == IDX_CTRL) && bus.wr_data[1];
  assign err_clr = wr_en && (wr_idx == IDX_STAT) && bus.wr_data[1];
  assign err_set = (wr_en && (!wr_hit || img_err)) || (bus.rd_valid && !rd_hit);

  // The read mux sees the values from before this cycle's write, so a
  // read and a write to the same address in one cycle return the old value.
  always_comb begin
    rd_word = '0;
    rd_hit  = 1'b1;
    case (rd_idx)
      IDX_REV:  rd_word = DATA_WIDTH'(REVISION);
      IDX_CTRL: rd_word = DATA_WIDTH'({stg_mode, 1'b0, stg_enable});
      IDX_WID:  rd_word = DATA_WIDTH'(stg_width);
      IDX_HGT:  rd_word = DATA_WIDTH'(stg_height);
      IDX_STAT: rd_word = DATA_WIDTH'({err, pending});
      IDX_CNT:  rd_word = DATA_WIDTH'(frame_cnt);
      default: begin
        rd_hit  = rd_user_hit;
        rd_word = rd_user_word;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stg_enable  <= 1'b0;
      stg_mode    <= 2'd0;
      stg_width   <= W_MAX;
      stg_height  <= H_MAX;
      stg_user    <= '0;
      act_enable  <= 1'b0;
      act_mode    <= 2'd0;
      act_width   <= W_MAX;
      act_height  <= H_MAX;
      act_user    <= '0;
      pending     <= 1'b0;
      err         <= 1'b0;
      frame_cnt   <= '0;
      wr_ready_q  <= 1'b0;
      rd_dvalid_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ready_q <= 1'b1;
      if (wr_en) begin
        case (wr_idx)
          IDX_CTRL: begin
            stg_enable <= bus.wr_data[0];
            stg_mode   <= bus.wr_data[3:2];
          end
          IDX_WID: if (wv != 12'd0) stg_width  <= (wv > W_MAX) ? W_MAX : wv;
          IDX_HGT: if (wv != 12'd0) stg_height <= (wv > H_MAX) ? H_MAX : wv;
          default: begin
            for (int k = 0; k < NUM_USER; k++)
              if (wr_user[k]) stg_user[k] <= bus.wr_data;
          end
        endcase
      end
      // Promotion uses the registered pending bit. An UPDATE that arrives
      // together with sof is therefore held for the next frame.
      if (sof && pending) begin
        act_enable <= stg_enable;
        act_mode   <= stg_mode;
        act_width  <= stg_width;
        act_height <= stg_height;
        act_user   <= stg_user;
      end
      pending <= upd_wr | (pending & ~sof);
      err     <= err_set | (err & ~err_clr);
      if (sof) frame_cnt <= frame_cnt + 32'd1;
      rd_dvalid_q <= bus.rd_valid;
      if (bus.rd_valid) rd_data_q <= rd_word;
    end
  end

  assign bus.wr_ready   = wr_ready_q;
  assign bus.rd_dvalid  = rd_dvalid_q;
  assign bus.rd_data    = rd_data_q;
  assign cfg_enable     = act_enable;
  assign cfg_mode       = act_mode;
  assign cfg_img_width  = act_width;
  assign cfg_img_height = act_height;
  assign cfg_user       = act_user;
  assign cfg_pending    = pending;
endmodule

// File: tb/tb_vfp_config_bank.sv
module tb_vfp_config_bank;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NU = 4;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic           sof = 1'b0;
  logic           cfg_enable, cfg_pending;
  logic [1:0]     cfg_mode;
  logic [11:0]    cfg_img_width, cfg_img_height;
  logic [NU*DW-1:0] cfg_user;

  vfp_config_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  vfp_config_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_USER(NU)) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus), .sof(sof),
    .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
    .cfg_img_width(cfg_img_width), .cfg_img_height(cfg_img_height),
    .cfg_user(cfg_user), .cfg_pending(cfg_pending)
  );

  always #5 aclk = ~aclk;

  typedef struct { string tag; logic [31:0] exp; } rd_exp_t;
  rd_exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int frames  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Read-data monitor: each returned word is checked against the oldest expectation.
  always @(negedge aclk) begin
    if (bus.rd_dvalid) begin
      if (sb.size() == 0) chk("sb_spurious_dvalid", 32'd1, 32'd0);
      else begin
        rd_exp_t e;
        e = sb.pop_front();
        chk(e.tag, bus.rd_data, e.exp);
      end
    end
  end

  // All tasks are entered and exited at a negedge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge aclk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    rd_exp_t e;
    e.tag = tag; e.exp = exp;
    sb.push_back(e);
    bus.rd_valid = 1'b1; bus.rd_addr = a;
    @(negedge aclk);
    bus.rd_valid = 1'b0;
  endtask

  task automatic wr_rd(input logic [7:0] wa, input logic [31:0] wd,
                       input logic [7:0] ra, input logic [31:0] exp, input string tag);
    rd_exp_t e;
    e.tag = tag; e.exp = exp;
    sb.push_back(e);
    bus.wr_valid = 1'b1; bus.wr_addr = wa; bus.wr_data = wd;
    bus.rd_valid = 1'b1; bus.rd_addr = ra;
    @(negedge aclk);
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
  endtask

  task automatic pulse_sof();
    sof = 1'b1; frames++;
    @(negedge aclk);
    sof = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1);
  end

  initial begin
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0;
    repeat (2) @(negedge aclk);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_dvalid", 32'(bus.rd_dvalid), 32'd0);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // reset state
    chk("rst_cfg_width", 32'(cfg_img_width), 32'd2751);
    chk("rst_cfg_height", 32'(cfg_img_height), 32'd1944);
    chk("rst_cfg_enable", 32'(cfg_enable), 32'd0);
    chk("rst_cfg_pending", 32'(cfg_pending), 32'd0);
    chk("wr_ready", 32'(bus.wr_ready), 32'd1);
    rd(8'h00, 32'h09072019, "rd_revision");
    rd(8'h08, 32'd2751, "rd_rst_width");
    rd(8'h0C, 32'd1944, "rd_rst_height");
    rd(8'h10, 32'd0, "rd_rst_status");
    rd(8'h14, 32'd0, "rd_rst_frame_cnt");

    // basic stage, update and promote
    wr(8'h08, 32'd1920);
    wr(8'h04, 32'h3);
    chk("pending_set", 32'(cfg_pending), 32'd1);
    rd(8'h04, 32'h1, "rd_ctrl_update_reads0");
    sof = 1'b1; frames++;
    chk("pre_sof_width", 32'(cfg_img_width), 32'd2751);
    @(negedge aclk); sof = 1'b0;
    chk("promote_width", 32'(cfg_img_width), 32'd1920);
    chk("promote_enable", 32'(cfg_enable), 32'd1);
    chk("promote_pending_clr", 32'(cfg_pending), 32'd0);

    // staging without update holds active
    wr(8'h08, 32'd1280);
    pulse_sof();
    chk("hold_width", 32'(cfg_img_width), 32'd1920);
    rd(8'h08, 32'd1280, "rd_staged_not_active");

    // clamp / zero reject / err W1C
    wr(8'h08, 32'd4000);
    rd(8'h08, 32'd2751, "rd_clamped_width");
    rd(8'h10, 32'h2, "rd_status_err_clamp");
    wr(8'h10, 32'h2);
    rd(8'h10, 32'h0, "rd_status_w1c");
    wr(8'h08, 32'd0);
    rd(8'h08, 32'd2751, "rd_zero_rejected");
    rd(8'h10, 32'h2, "rd_status_err_zero");
    wr(8'h0C, 32'd2000);
    rd(8'h0C, 32'd1944, "rd_clamped_height");
    wr(8'h10, 32'h2);
    rd(8'h40, 32'h0, "rd_unmapped_zero");
    rd(8'h10, 32'h2, "rd_status_err_unmapped");
    // clear and new error in the same cycle: err stays set
    wr_rd(8'h10, 32'h2, 8'h40, 32'h0, "rd_unmapped_during_w1c");
    rd(8'h10, 32'h2, "rd_status_err_sticky");
    wr(8'h10, 32'h2);
    wr(8'h44, 32'h1234);
    rd(8'h10, 32'h2, "rd_status_err_unmapped_wr");
    wr(8'h10, 32'h2);
    // same-address read/write returns the pre-write value
    wr_rd(8'h08, 32'd100, 8'h08, 32'd2751, "rd_raw_prewrite");
    rd(8'h08, 32'd100, "rd_raw_postwrite");

    // UPDATE together with sof: deferred one frame
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h04; bus.wr_data = 32'h2;
    sof = 1'b1; frames++;
    @(negedge aclk);
    bus.wr_valid = 1'b0; sof = 1'b0;
    chk("upd_sof_pending", 32'(cfg_pending), 32'd1);
    chk("upd_sof_width_hold", 32'(cfg_img_width), 32'd1920);
    chk("upd_sof_enable_hold", 32'(cfg_enable), 32'd1);
    pulse_sof();
    chk("upd_next_sof_width", 32'(cfg_img_width), 32'd100);
    chk("upd_next_sof_enable", 32'(cfg_enable), 32'd0);

    // staging write with the promoting sof: active takes the old staged value
    wr(8'h04, 32'hE);
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h08; bus.wr_data = 32'd500;
    sof = 1'b1; frames++;
    @(negedge aclk);
    bus.wr_valid = 1'b0; sof = 1'b0;
    chk("wr_sof_width_old", 32'(cfg_img_width), 32'd100);
    chk("wr_sof_mode", 32'(cfg_mode), 32'd3);
    chk("wr_sof_pending_clr", 32'(cfg_pending), 32'd0);
    rd(8'h08, 32'd500, "rd_wr_sof_staged_new");
    wr(8'h04, 32'h2);
    pulse_sof();
    chk("next_update_width", 32'(cfg_img_width), 32'd500);
    chk("next_update_mode", 32'(cfg_mode), 32'd0);

    // frame counter
    rd(8'h14, 32'(frames), "rd_frame_cnt_a");
    repeat (3) pulse_sof();
    rd(8'h14, 32'(frames), "rd_frame_cnt_plus3");
    force dut.frame_cnt = 32'hFFFF_FFFF;
    rd(8'h14, 32'hFFFF_FFFF, "rd_frame_cnt_preload");
    release dut.frame_cnt;
    pulse_sof();
    rd(8'h14, 32'h0, "rd_frame_cnt_wrap");

    // user register, then reset mid-frame with an update pending
    wr(8'h24, 32'hA5A5A5A5);
    rd(8'h24, 32'hA5A5A5A5, "rd_user3_staged");
    wr(8'h04, 32'h7);
    pulse_sof();
    chk("user3_active", cfg_user[127:96], 32'hA5A5A5A5);
    chk("user0_active", cfg_user[31:0], 32'h0);
    pulse_sof();
    wr(8'h0C, 32'd720);
    wr(8'h04, 32'h2);
    repeat (3) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_user3", cfg_user[127:96], 32'h0);
    chk("arst_width", 32'(cfg_img_width), 32'd2751);
    chk("arst_height", 32'(cfg_img_height), 32'd1944);
    chk("arst_enable", 32'(cfg_enable), 32'd0);
    chk("arst_mode", 32'(cfg_mode), 32'd0);
    chk("arst_pending", 32'(cfg_pending), 32'd0);
    chk("arst_wr_ready", 32'(bus.wr_ready), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    pulse_sof();
    chk("post_rst_no_promote_h", 32'(cfg_img_height), 32'd1944);
    rd(8'h14, 32'h1, "rd_post_rst_frame_cnt");
    rd(8'h24, 32'h0, "rd_post_rst_user3");
    rd(8'h0C, 32'd1944, "rd_post_rst_height");

    repeat (3) @(negedge aclk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
